// File: rtl/bht_predictor.sv
// Branch history table: direct-mapped 2-bit saturating counters indexed by PC[IDXW:1].
// The table is cleared by a self-timed INIT sweep after reset or flush; lookups have one cycle of latency.
module bht_predictor #(
  parameter int NR_ENTRIES = 128,
  parameter int VLEN       = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  output logic            ready_o,
  output logic            lookup_valid_o,
  output logic            lookup_taken_o
);

  localparam int IDXW = $clog2(NR_ENTRIES);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]      r_state;
  logic [IDXW-1:0] r_clr_cnt;
  logic            r_lookup_valid;
  logic            r_lookup_taken;
  logic            r_valid [NR_ENTRIES];
  logic [1:0]      r_ctr   [NR_ENTRIES];

  logic [IDXW-1:0] w_lookup_idx;
  logic [IDXW-1:0] w_update_idx;
  logic            w_ready;
  logic            w_upd_acc;
  logic            w_lookup_hit;
  logic            w_clr_last;
  logic [1:0]      w_upd_ctr_next;
  logic            w_unused_pc;

  // Bit 0 is dropped because compressed instructions are 2-byte aligned.
  assign w_lookup_idx = lookup_pc_i[IDXW:1];
  assign w_update_idx = update_pc_i[IDXW:1];
  assign w_unused_pc  = ^{lookup_pc_i[VLEN-1:IDXW+1], lookup_pc_i[0],
                          update_pc_i[VLEN-1:IDXW+1], update_pc_i[0]};

  assign w_ready      = (r_state == ST_READY);
  assign w_upd_acc    = update_valid_i && w_ready && !flush_i;
  assign w_lookup_hit = lookup_valid_i && w_ready && !flush_i && r_valid[w_lookup_idx];
  assign w_clr_last   = (r_clr_cnt == IDXW'(NR_ENTRIES - 1));

  always_comb begin
    w_upd_ctr_next = r_ctr[w_update_idx];
    if (!r_valid[w_update_idx]) begin
      w_upd_ctr_next = update_taken_i ? 2'b10 : 2'b01;
    end else if (update_taken_i) begin
      if (r_ctr[w_update_idx] != 2'b11) w_upd_ctr_next = r_ctr[w_update_idx] + 2'b01;
    end else begin
      if (r_ctr[w_update_idx] != 2'b00) w_upd_ctr_next = r_ctr[w_update_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (flush_i) begin
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (w_clr_last) r_state <= ST_READY;
          end
        end
        default: begin
          if (flush_i) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lookup_valid <= 1'b0;
      r_lookup_taken <= 1'b0;
    end else begin
      r_lookup_valid <= w_lookup_hit;
      r_lookup_taken <= w_lookup_hit && r_ctr[w_lookup_idx][1];
    end
  end

  // Table contents are left unreset; the INIT sweep is what defines them.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_INIT) begin
      r_valid[r_clr_cnt] <= 1'b0;
      r_ctr[r_clr_cnt]   <= 2'b01;
    end else if (w_upd_acc) begin
      r_valid[w_update_idx] <= 1'b1;
      r_ctr[w_update_idx]   <= w_upd_ctr_next;
    end
  end

  assign ready_o        = w_ready;
  assign lookup_valid_o = r_lookup_valid;
  assign lookup_taken_o = r_lookup_taken;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed-vector bench for bht_predictor with hand-computed expectations.
module tb_bht_predictor;

  localparam int VLEN = 64;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            lookup_valid_i = 1'b0;
  logic [VLEN-1:0] lookup_pc_i = '0;
  logic            update_valid_i = 1'b0;
  logic [VLEN-1:0] update_pc_i = '0;
  logic            update_taken_i = 1'b0;
  logic            ready_o;
  logic            lookup_valid_o;
  logic            lookup_taken_o;

  int n_vec = 0;
  int n_err = 0;

  bht_predictor #(.NR_ENTRIES(128), .VLEN(VLEN)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_pc_i    (lookup_pc_i),
    .update_valid_i (update_valid_i),
    .update_pc_i    (update_pc_i),
    .update_taken_i (update_taken_i),
    .ready_o        (ready_o),
    .lookup_valid_o (lookup_valid_o),
    .lookup_taken_o (lookup_taken_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_update(input logic [VLEN-1:0] pc, input logic taken);
    update_valid_i = 1'b1;
    update_pc_i    = pc;
    update_taken_i = taken;
    tick();
    update_valid_i = 1'b0;
  endtask

  task automatic do_lookup(input string tag, input logic [VLEN-1:0] pc,
                           input logic exp_v, input logic exp_t);
    lookup_valid_i = 1'b1;
    lookup_pc_i    = pc;
    tick();
    lookup_valid_i = 1'b0;
    check_val({tag, "_valid"}, int'(lookup_valid_o), int'(exp_v));
    check_val({tag, "_taken"}, int'(lookup_taken_o), int'(exp_t));
  endtask

  // Counts edges until ready_o rises; optionally drives a lookup throughout and
  // an update on the last INIT cycle, both of which must have no effect.
  task automatic wait_ready(input string tag, input logic probe);
    int n = 0;
    int seen_valid = 0;
    while (!ready_o && n < 400) begin
      lookup_valid_i = probe;
      lookup_pc_i    = 64'h8000_0010;
      if (probe && n == 127) begin
        update_valid_i = 1'b1;
        update_pc_i    = 64'h40;
        update_taken_i = 1'b1;
      end
      tick();
      update_valid_i = 1'b0;
      if (lookup_valid_o) seen_valid++;
      n++;
    end
    lookup_valid_i = 1'b0;
    check_val({tag, "_init_cycles"}, n, 128);
    check_val({tag, "_init_lookup_valid"}, seen_valid, 0);
  endtask

  initial begin
    // Reset behaviour
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_ready", int'(ready_o), 0);
    check_val("rst_lookup_valid", int'(lookup_valid_o), 0);
    check_val("rst_lookup_taken", int'(lookup_taken_o), 0);
    rst_i = 1'b0;
    wait_ready("post_rst", 1'b1);
    check_val("post_rst_ready", int'(ready_o), 1);

    // Saturation up at 0x8000_0010: ctr 10,11,11,11
    do_lookup("cold", 64'h8000_0010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_update(64'h8000_0010, 1'b1);
      do_lookup($sformatf("sat_up%0d", i), 64'h8000_0010, 1'b1, 1'b1);
    end

    // Hysteresis: 11 -> 10 (T) -> 01 (NT) -> 00 -> 00, then taken gives 01 (NT)
    do_update(64'h8000_0010, 1'b0);
    do_lookup("hyst1", 64'h8000_0010, 1'b1, 1'b1);
    do_update(64'h8000_0010, 1'b0);
    do_lookup("hyst2", 64'h8000_0010, 1'b1, 1'b0);
    do_update(64'h8000_0010, 1'b0);
    do_update(64'h8000_0010, 1'b0);
    do_update(64'h8000_0010, 1'b0);
    do_lookup("sat_dn", 64'h8000_0010, 1'b1, 1'b0);
    do_update(64'h8000_0010, 1'b1);
    do_lookup("sat_dn_floor", 64'h8000_0010, 1'b1, 1'b0);
    do_update(64'h8000_0010, 1'b1);
    do_lookup("sat_dn_recover", 64'h8000_0010, 1'b1, 1'b1);

    // Aliasing and compressed-instruction indexing
    do_update(64'h102, 1'b1);
    do_lookup("alias_256", 64'h202, 1'b1, 1'b1);
    do_lookup("rvc_neighbour", 64'h100, 1'b0, 1'b0);
    do_lookup("pc_bit0", 64'h103, 1'b1, 1'b1);
    do_update(64'h100, 1'b0);
    do_lookup("idx0_written", 64'h100, 1'b1, 1'b0);
    do_lookup("idx1_intact", 64'h102, 1'b1, 1'b1);

    // Same-cycle lookup/update: old value is returned, no bypass
    do_update(64'h40, 1'b0);
    lookup_valid_i = 1'b1;
    lookup_pc_i    = 64'h40;
    do_update(64'h40, 1'b1);
    lookup_valid_i = 1'b0;
    check_val("hazard_valid", int'(lookup_valid_o), 1);
    check_val("hazard_taken", int'(lookup_taken_o), 0);
    do_lookup("hazard_after", 64'h40, 1'b1, 1'b1);

    // Flush with same-cycle lookup and update
    flush_i        = 1'b1;
    lookup_valid_i = 1'b1;
    lookup_pc_i    = 64'h40;
    do_update(64'h40, 1'b1);
    flush_i        = 1'b0;
    lookup_valid_i = 1'b0;
    check_val("flush_ready", int'(ready_o), 0);
    check_val("flush_lookup_valid", int'(lookup_valid_o), 0);
    wait_ready("post_flush", 1'b1);
    do_lookup("flushed_40", 64'h40, 1'b0, 1'b0);
    do_lookup("flushed_sat", 64'h8000_0010, 1'b0, 1'b0);
    do_lookup("flushed_102", 64'h102, 1'b0, 1'b0);
    do_update(64'h40, 1'b0);
    do_lookup("refill_40", 64'h40, 1'b1, 1'b0);

    // Reset mid-operation restarts the full INIT sweep
    rst_i = 1'b1;
    #3;
    check_val("midrst_ready", int'(ready_o), 0);
    tick();
    rst_i = 1'b0;
    wait_ready("post_midrst", 1'b0);
    do_lookup("midrst_40", 64'h40, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 128: number of prediction entries; power of two, >= 2.
REQ-002 SHALL have parameter VLEN, default 64: virtual PC width in bits.
REQ-003 SHALL have the following ports:
- clk_i  input  1  sole clock; all state updates on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  clears all predictor state.
- lookup_valid_i  input  1  lookup request this cycle.
- lookup_pc_i  input  VLEN  PC to predict.
- update_valid_i  input  1  resolved-branch update this cycle.
- update_pc_i  input  VLEN  PC of the resolved branch.
- update_taken_i  input  1  resolved direction (1 = taken).
- ready_o  output  1  table initialised; lookups and updates are accepted.
- lookup_valid_o  output  1  prediction valid, one cycle after the request.
- lookup_taken_o  output  1  predicted direction.

Function
REQ-004 SHALL hold per entry a valid bit and a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-005 SHALL index entries with PC[IDXW:1], where IDXW = log2(NR_ENTRIES); bit 0 is ignored (2-byte RVC alignment).
REQ-006 SHALL implement a two-state FSM, INIT and READY, plus an init counter clr_cnt of width IDXW.
REQ-007 SHALL, in INIT, write entry[clr_cnt] = {valid=0, ctr=01} each cycle and then increment clr_cnt.
REQ-008 SHALL transition INIT -> READY in the cycle that clears entry NR_ENTRIES-1, after exactly NR_ENTRIES INIT cycles.
REQ-009 SHALL, on flush_i=1 in READY, transition to INIT next cycle with clr_cnt=0.
REQ-010 SHALL, on flush_i=1 while in INIT, restart clr_cnt at 0.
REQ-011 SHALL drive ready_o=1 iff the FSM is in READY; ready_o is registered state, not derived from flush_i.
REQ-012 SHALL register lookups with 1-cycle latency:
- lookup_valid_o(t+1) = lookup_valid_i && READY && !flush_i && entry.valid, all at t.
- lookup_taken_o(t+1) = entry.ctr[1] at t when that valid term is 1, else 0.
REQ-013 SHALL read table state before that cycle's update (read-before-write) when a lookup and an update target the same index in the same cycle; no bypass.
REQ-014 SHALL accept an update only when READY && !flush_i; otherwise the update is dropped with no state change.
REQ-015 SHALL, on an accepted update to an invalid entry, set valid=1 and ctr = update_taken_i ? 10 : 01.
REQ-016 SHALL, on an accepted update to a valid entry:
- taken: increment ctr, saturating at 11.
- not-taken: decrement ctr, saturating at 00.
REQ-017 SHALL apply at most one table write per cycle; INIT clearing and updates are mutually exclusive by REQ-014.
REQ-018 SHALL never stall or back-pressure: no ready/valid on the lookup or update paths other than ready_o.

Reset
REQ-019 SHALL, while rst_i=1, asynchronously force:
- FSM=INIT, clr_cnt=0.
- ready_o=0, lookup_valid_o=0, lookup_taken_o=0.
REQ-020 SHALL leave table contents undefined after reset and make them defined only by INIT clearing; no lookup can return them before READY.
REQ-021 SHALL, on reset asserted mid-INIT or mid-operation, abandon all progress and restart INIT from clr_cnt=0 after rst_i deasserts.

Verification
REQ-022 Bench SHALL cover post-reset init: deassert rst_i -> ready_o=0 for exactly 128 cycles, 1 on cycle 129; a lookup during INIT gives lookup_valid_o=0.
REQ-023 Bench SHALL cover saturation up: 4 taken updates to PC 0x8000_0010 -> ctr 10,11,11,11; a lookup at that PC gives valid_o=1, taken_o=1 one cycle later.
REQ-024 Bench SHALL cover hysteresis: from ctr=11, one not-taken update -> lookup still taken=1; a second not-taken -> taken=0; further not-taken updates hold ctr at 00.
REQ-025 Bench SHALL cover aliasing and RVC indexing: PC 0x102 and 0x102+256 (NR_ENTRIES=128) share an entry; 0x100 and 0x102 do not; PC bit 0 is ignored.
REQ-026 Bench SHALL cover same-cycle hazard: lookup and update (taken) to the same entry at ctr=01 -> lookup returns taken=0; the next lookup returns taken=1.
REQ-027 Bench SHALL cover flush: flush_i pulse in READY with a same-cycle update -> update dropped, ready_o=0 next cycle, 128 INIT cycles; afterwards all lookups return valid_o=0.
